// File: rtl/imem_pkg.sv
// +-------------------------------------------------------------------+
// | imem_pkg: shared defaults, FSM states and requester ids for imem  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

  localparam int          AW_DEF      = 10;
  localparam int          DW_DEF      = 32;
  localparam logic [31:0] CLR_VAL_DEF = 32'h0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } req_id_t;

  // Grant vectors are indexed by requester id: bit 0 fetch, bit 1 loader.
  function automatic logic [1:0] id_onehot(input req_id_t id);
    return (id == FETCH) ? 2'b01 : 2'b10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_if.sv
// +-------------------------------------------------------------------+
// | imem_if: fetch, loader and memory-port signals of imem_ctrl       |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

interface imem_if
  import imem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  // master: the surroundings (requesters and RAM); slave: the controller.
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// +-------------------------------------------------------------------+
// | rr_arb2: two-requester round-robin arbiter with enable            |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import imem_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       en,
  input  wire logic [1:0] req,
  output logic      [1:0] gnt
);

  req_id_t last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = id_onehot(FETCH);
        2'b10:   gnt = id_onehot(LOADER);
        2'b11:   gnt = (last_gnt == LOADER) ? id_onehot(FETCH) : id_onehot(LOADER);
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset points at the loader so fetch wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= LOADER;
    end else if (gnt[0]) begin
      last_gnt <= FETCH;
    end else if (gnt[1]) begin
      last_gnt <= LOADER;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_ctrl.sv
// +-------------------------------------------------------------------+
// | imem_ctrl: instruction-memory clear sequencer and port arbiter    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module imem_ctrl
  import imem_pkg::*;
#(
  parameter int          AW      = AW_DEF,
  parameter int          DW      = DW_DEF,
  parameter logic [DW-1:0] CLR_VAL = DW'(CLR_VAL_DEF)
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic clr_start,
  output logic      busy,
  imem_if.slave     bus
);

  localparam logic [AW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          f_rvalid_q;
  logic          l_rvalid_q;
  logic [1:0]    gnt;
  logic          run_en;

  assign run_en = (state == RUN);
  assign busy   = (state == CLEAR);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_en),
    .req     ({bus.l_req, bus.f_req}),
    .gnt     (gnt)
  );

  assign bus.f_gnt    = gnt[0];
  assign bus.l_gnt    = gnt[1];
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.f_rdata  = bus.m_rdata;
  assign bus.l_rdata  = bus.m_rdata;

  // The clear strobe is gated by reset_n so the port goes quiet the
  // instant reset asserts, not at the next edge.
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (state == CLEAR) begin
      if (reset_n) begin
        bus.m_en    = 1'b1;
        bus.m_we    = 1'b1;
        bus.m_addr  = clr_cnt;
        bus.m_wdata = CLR_VAL;
      end
    end else begin
      bus.m_en    = |gnt;
      bus.m_we    = gnt[1] & bus.l_we;
      bus.m_addr  = gnt[0] ? bus.f_addr : bus.l_addr;
      bus.m_wdata = bus.l_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      f_rvalid_q <= gnt[0];
      l_rvalid_q <= gnt[1] & ~bus.l_we;
      unique case (state)
        CLEAR: begin
          if (clr_start) begin
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == CNT_MAX) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_ctrl.sv
// +-------------------------------------------------------------------+
// | tb_imem_ctrl: randomized bench for imem_ctrl with reference model |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_imem_ctrl;

  localparam int            AW      = 10;
  localparam int            DW      = 32;
  localparam int            DEPTH   = 1 << AW;
  localparam logic [DW-1:0] CLR_VAL = 32'h0;

  logic clk = 1'b0;
  logic reset_n;
  logic clr_start;
  logic busy;

  imem_if #(.AW(AW), .DW(DW)) bus ();

  imem_ctrl #(.AW(AW), .DW(DW), .CLR_VAL(CLR_VAL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_start (clr_start),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata     <= ram[bus.m_addr];
    end
  end

  // Reference model state
  bit            m_clear;
  int            m_idx;
  bit            m_last_f;
  bit            e_frv, e_lrv;
  logic [DW-1:0] e_fd, e_ld;
  logic [DW-1:0] ref_mem [DEPTH];

  bit obs_busy, obs_fg, obs_lg;
  int n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic reset_model();
    m_clear  = 1'b1;
    m_idx    = 0;
    m_last_f = 1'b0;
    e_frv    = 1'b0;
    e_lrv    = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},   busy, 1);
    check({tag, "_f_gnt"},  bus.f_gnt, 0);
    check({tag, "_l_gnt"},  bus.l_gnt, 0);
    check({tag, "_f_rv"},   bus.f_rvalid, 0);
    check({tag, "_l_rv"},   bus.l_rvalid, 0);
    check({tag, "_m_en"},   bus.m_en, 0);
    check({tag, "_m_we"},   bus.m_we, 0);
    check({tag, "_m_addr"}, bus.m_addr, 0);
    check({tag, "_m_wdat"}, bus.m_wdata, 0);
  endtask

  task automatic set_idle();
    clr_start   = 1'b0;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  // One clock cycle: inputs are already set (called at posedge+1).
  task automatic cycle();
    int win;
    @(negedge clk);
    obs_busy = busy;
    obs_fg   = bus.f_gnt;
    obs_lg   = bus.l_gnt;
    win = 0;
    if (!m_clear) begin
      if (bus.f_req && bus.l_req) win = m_last_f ? 2 : 1;
      else if (bus.f_req)         win = 1;
      else if (bus.l_req)         win = 2;
    end
    check("busy",  busy, m_clear);
    check("f_gnt", bus.f_gnt, win == 1);
    check("l_gnt", bus.l_gnt, win == 2);
    if (m_clear) begin
      check("clr_m_en",   bus.m_en, 1);
      check("clr_m_we",   bus.m_we, 1);
      check("clr_m_addr", bus.m_addr, m_idx);
      check("clr_m_wdat", bus.m_wdata, CLR_VAL);
    end else begin
      check("m_en", bus.m_en, win != 0);
      check("m_we", bus.m_we, (win == 2) && bus.l_we);
      if (win == 1) check("m_addr_f", bus.m_addr, bus.f_addr);
      if (win == 2) check("m_addr_l", bus.m_addr, bus.l_addr);
      if (win == 2 && bus.l_we) check("m_wdata", bus.m_wdata, bus.l_wdata);
    end
    check("f_rvalid", bus.f_rvalid, e_frv);
    if (e_frv) check("f_rdata", bus.f_rdata, e_fd);
    check("l_rvalid", bus.l_rvalid, e_lrv);
    if (e_lrv) check("l_rdata", bus.l_rdata, e_ld);

    e_frv = (win == 1);
    if (win == 1) e_fd = ref_mem[bus.f_addr];
    e_lrv = (win == 2) && !bus.l_we;
    if (e_lrv) e_ld = ref_mem[bus.l_addr];
    if (win == 2 && bus.l_we) ref_mem[bus.l_addr] = bus.l_wdata;
    if (win != 0) m_last_f = (win == 1);
    if (m_clear) begin
      ref_mem[m_idx] = CLR_VAL;
      if (clr_start)              m_idx = 0;
      else if (m_idx == DEPTH-1) begin m_clear = 1'b0; m_idx = 0; end
      else                        m_idx++;
    end else if (clr_start) begin
      m_clear = 1'b1;
      m_idx   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_clear(inout int n);
    for (int i = 0; i < 3000 && m_clear; i++) begin
      cycle();
      if (obs_busy) n++;
    end
    check("clear_done", m_clear, 0);
  endtask

  task automatic rand_cycles(input int count);
    for (int c = 0; c < count; c++) begin
      if (!bus.f_req || obs_fg) begin
        bus.f_req  = ($urandom_range(0, 3) != 0);
        bus.f_addr = AW'($urandom_range(0, 15));
      end
      if (!bus.l_req || obs_lg) begin
        bus.l_req   = ($urandom_range(0, 2) != 0);
        bus.l_we    = $urandom_range(0, 1) == 1;
        bus.l_addr  = AW'($urandom_range(0, 15));
        bus.l_wdata = $urandom;
      end
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         n;
    logic [5:0] pat;
    n_tests = 0;
    n_fail  = 0;
    set_idle();
    reset_n     = 1'b0;
    bus.f_req   = 1'b1;
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 10'h3;
    bus.l_wdata = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    set_idle();
    reset_n = 1'b1;
    reset_model();

    // Power-on clear
    n = 0;
    run_clear(n);
    check("init_clear_len", n, 1024);
    check("busy_after_clear", busy, 0);

    // Write then read
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'h012; bus.l_wdata = 32'hDEADBEEF;
    cycle();
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 10'h012;
    cycle();
    check("wr_rd_valid", bus.f_rvalid, 1);
    check("wr_rd_data", bus.f_rdata, 32'hDEADBEEF);
    bus.f_req = 1'b0;
    cycle();

    // Contention: leave the pointer on the loader first
    bus.l_req = 1'b1; bus.l_addr = 10'h001;
    cycle();
    bus.f_req = 1'b1; bus.f_addr = 10'h012; bus.l_addr = 10'h012;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      pat = {pat[4:0], obs_fg};
    end
    check("contention_pat", pat, 6'b101010);
    set_idle();
    cycle();

    // Mid-run clear coincident with a fetch grant
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'h005; bus.l_wdata = 32'h1234;
    cycle();
    set_idle();
    bus.f_req = 1'b1; bus.f_addr = 10'h005; clr_start = 1'b1;
    cycle();
    check("midclr_gnt", obs_fg, 1);
    check("midclr_rvalid", bus.f_rvalid, 1);
    check("midclr_rdata", bus.f_rdata, 32'h1234);
    check("midclr_busy", busy, 1);
    set_idle();
    n = 0;
    run_clear(n);
    check("midclr_len", n, 1024);
    bus.f_req = 1'b1; bus.f_addr = 10'h005;
    cycle();
    bus.f_req = 1'b0;
    check("cleared_data", bus.f_rdata, 0);
    cycle();

    // clr_start during CLEAR at count 500
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    n = 0;
    for (int i = 0; i < 600 && m_idx != 500; i++) begin
      cycle();
      if (obs_busy) n++;
    end
    clr_start = 1'b1;
    cycle();
    if (obs_busy) n++;
    clr_start = 1'b0;
    run_clear(n);
    check("restart_len", n, 1525);

    // Random traffic with one embedded clear
    rand_cycles(1200);
    clr_start = 1'b1;
    rand_cycles(1);
    clr_start = 1'b0;
    rand_cycles(2000);
    set_idle();
    n = 0;
    run_clear(n);

    // Async reset mid-clear
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    for (int i = 0; i < 400 && m_idx != 300; i++) cycle();
    bus.f_req = 1'b1; bus.l_req = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async");
    @(posedge clk);
    #1;
    check_reset("async_hold");
    set_idle();
    reset_n = 1'b1;
    reset_model();
    n = 0;
    run_clear(n);
    check("post_rst_len", n, 1024);

    // Async reset with a read pending drops its rvalid
    bus.f_req = 1'b1; bus.f_addr = 10'h007;
    cycle();
    check("pend_rvalid", bus.f_rvalid, 1);
    bus.f_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset("pend");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_model();
    n = 0;
    run_clear(n);
    rand_cycles(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_ctrl.md
# imem_ctrl

Controller sitting between the instruction memory and its two users: the fetch stage and the test/program loader. After reset, and on request, it sequences a full clear of the memory, replacing per-test reload-over-stale-contents with a defined all-CLR_VAL image. In normal operation it arbitrates the single memory port round-robin between fetch reads and loader reads/writes. It returns read data one cycle after grant.

## Interface
- AW, 10: word-address width; memory depth is 2^AW words.
- DW, 32: data width.
- CLR_VAL, 32'h0: word written to every location during a clear.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clr_start  in  1  one-cycle pulse that requests a full memory clear.
- busy  out  1  high while clearing.
- f_req  in  1  fetch read request.
- f_addr  in  AW  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DW  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader request is a write.
- l_addr  in  AW  loader word address.
- l_wdata  in  DW  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DW  loader read data.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory word address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; synchronous RAM with 1-cycle latency.

## Operation
- **States:**
  - CLEAR: the counter clr_cnt walks the memory writing CLR_VAL.
  - RUN: arbitration.
- **Reset (reset_n low):**
  - State goes to CLEAR, clr_cnt=0, last-grant pointer set to "loader", so fetch wins the first tie.
  - busy=1. f_gnt, l_gnt, f_rvalid, l_rvalid all 0.
  - m_en, m_we, m_addr, m_wdata all 0.
- **CLEAR, each cycle:**
  - Drive m_en=1, m_we=1, m_addr=clr_cnt, m_wdata=CLR_VAL.
  - No grants.
  - When clr_cnt = 2^AW−1, the next state is RUN and clr_cnt wraps to 0. The wrap is intentional; no overflow flag is produced.
- **RUN:**
  - busy=0.
  - Only one requester: grant it.
  - Both requesting: grant the one not granted last.
  - The pointer updates only on an actual grant.
- **Grant outputs (combinational from req/state):**
  - Grant drives m_en=1 and the winner's address.
  - m_we = l_we for the loader, 0 for fetch.
  - m_wdata = l_wdata.
  - No grant: m_en=0, m_we=0.
- **Read return:**
  - A granted read sets f_rvalid or l_rvalid (registered) in the next cycle.
  - f_rdata and l_rdata both pass m_rdata through.
  - Loader writes produce no rvalid.
- **Requester rules:**
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - There are no outstanding-transaction limits; back-to-back grants are allowed every cycle.
- **clr_start in RUN:**
  - Next state is CLEAR with clr_cnt=0.
  - A read granted in the same cycle as clr_start is still accepted, and its rvalid is delivered in the first CLEAR cycle.
- **clr_start in CLEAR:** restarts clr_cnt at 0.
- **reset_n mid-clear or mid-read:** abandons everything immediately. A pending rvalid is dropped.

## Timing
- Clear duration: exactly 2^AW cycles from the first CLEAR cycle to the first RUN cycle (1024 for default AW).
- Read latency: grant in cycle N, rvalid and data in cycle N+1.
- Write: committed at the end of grant cycle N. A read of the same address granted in N+1 returns the new data in N+2.
- Under continuous dual requests, each requester gets exactly every other cycle.

## Structure
- Package imem_pkg holds:
  - AW and DW defaults.
  - CLR_VAL default.
  - The state enum {CLEAR, RUN}.
  - The requester id encoding (FETCH=0, LOADER=1).
- Sub-module rr_arb2:
  - Two-requester round-robin arbiter with a last-grant flop and an enable input.
  - imem_ctrl holds it disabled during CLEAR.
- imem_ctrl holds the FSM, clear counter and return-path flops.

## Test plan
1. **Reset clear:** release reset_n.
   - busy stays 1 for 1024 cycles; m_addr steps 0..1023 with m_we=1 and m_wdata=0.
   - busy=0 in cycle 1025; no grants before that.
2. **Write then read:**
   - Loader writes 0xDEADBEEF to address 0x012.
   - Fetch reads 0x012 in the next cycle; f_rvalid is asserted one cycle after f_gnt with f_rdata=0xDEADBEEF.
3. **Contention:** f_req and l_req (reads) both held for 6 cycles.
   - Grants alternate F,L,F,L,F,L.
   - Each rvalid lands on the matching requester one cycle later.
4. **Mid-run clear:** clr_start pulses in the same cycle as an f_gnt read of 0x005, which previously held 0x1234.
   - f_rvalid is asserted next cycle with 0x1234.
   - busy=1 for 1024 cycles, then a read of 0x005 returns 0.
5. **clr_start during CLEAR:** pulse at clr_cnt=500.
   - Counter restarts at 0; total busy time is 501+1024 cycles.
6. **Async reset mid-clear:** reset_n is pulled low asynchronously at clr_cnt=300.
   - Outputs go to reset values immediately without waiting for a clock edge.
   - After release, the clear restarts from address 0.
